// File: rtl/polar_enc_engine.sv
// Polar encoder engine: reads packets from an input memory, encodes each
// with u * F^(tensor n) in place, and writes one codeword per packet.
module polar_enc_engine #(
   parameter int LOG_NMAX = 9,
   parameter int PKT_AW   = 6,
   parameter int RA_W     = PKT_AW + 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       module_en,
   output logic [RA_W-1:0]            raddr,
   input  logic [(1<<LOG_NMAX)-1:0]   rdata,
   output logic                       wr_en,
   output logic [PKT_AW-1:0]          waddr,
   output logic [(1<<LOG_NMAX)-1:0]   wdata,
   output logic                       proc_done
);

   localparam int NMAX = 1 << LOG_NMAX;
   localparam int SW   = $clog2(LOG_NMAX + 1);
   localparam int CW   = PKT_AW + 1;

   typedef enum logic [2:0] {
      IDLE, CNT, MODE, MASK, LOADU, ENC, WRITE, DONE
   } state_t;

   state_t            state, state_nx;
   logic [CW-1:0]     pcnt, pcnt_in;
   logic [PKT_AW-1:0] pidx;
   logic [1:0]        mode;
   logic [SW-1:0]     stage, n_st;
   logic [NMAX-1:0]   mask, x, x_stage, len_mask;
   logic [NMAX-1:0]   wdata_q;
   logic [PKT_AW-1:0] waddr_q;
   logic [RA_W-1:0]   p_ext;
   logic              last;

   assign pcnt_in = (rdata[PKT_AW:0] > CW'(1 << PKT_AW)) ?
                    CW'(1 << PKT_AW) : rdata[PKT_AW:0];
   assign last    = (CW'(pidx) + CW'(1)) >= pcnt;
   assign p_ext   = RA_W'(pidx);

   always_comb begin
      n_st     = '0;
      len_mask = '0;
      unique case (mode)
         2'd0: begin
            n_st     = SW'(LOG_NMAX - 2);
            len_mask = {NMAX{1'b1}} >> (NMAX - NMAX / 4);
         end
         2'd1: begin
            n_st     = SW'(LOG_NMAX - 1);
            len_mask = {NMAX{1'b1}} >> (NMAX - NMAX / 2);
         end
         2'd2: begin
            n_st     = SW'(LOG_NMAX);
            len_mask = {NMAX{1'b1}};
         end
         default: begin
            n_st     = '0;
            len_mask = '0;
         end
      endcase
   end

   // One butterfly stage; bits at N and above stay zero on their own.
   always_comb begin
      x_stage = x;
      for (int k = 0; k < LOG_NMAX; k++) begin
         if (stage == SW'(k)) begin
            for (int i = 0; i < NMAX; i++) begin
               if (((i >> k) & 1) == 0 && (i + (1 << k)) < NMAX)
                  x_stage[i] = x[i] ^ x[i + (1 << k)];
            end
         end
      end
   end

   always_comb begin
      raddr = '0;
      unique case (state)
         CNT:     raddr = RA_W'(1);
         MODE:    raddr = RA_W'(3) * p_ext + RA_W'(2);
         MASK:    raddr = RA_W'(3) * p_ext + RA_W'(3);
         WRITE:   raddr = RA_W'(3) * p_ext + RA_W'(4);
         default: raddr = '0;
      endcase
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:  if (module_en) state_nx = CNT;
         CNT:   state_nx = (pcnt_in == '0) ? DONE : MODE;
         MODE:  state_nx = MASK;
         MASK:  state_nx = LOADU;
         LOADU: state_nx = (n_st == '0) ? WRITE : ENC;
         ENC:   if (stage == n_st - SW'(1)) state_nx = WRITE;
         WRITE: state_nx = last ? DONE : MODE;
         DONE:  state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         pcnt    <= '0;
         pidx    <= '0;
         mode    <= '0;
         mask    <= '0;
         x       <= '0;
         stage   <= '0;
         waddr_q <= '0;
         wdata_q <= '0;
      end else begin
         state <= state_nx;
         unique case (state)
            CNT: begin
               pcnt <= pcnt_in;
               pidx <= '0;
            end
            MODE:  mode <= rdata[1:0];
            MASK:  mask <= rdata;
            LOADU: begin
               x     <= rdata & ~mask & len_mask;
               stage <= '0;
            end
            ENC: begin
               x     <= x_stage;
               stage <= stage + SW'(1);
            end
            WRITE: begin
               waddr_q <= pidx;
               wdata_q <= x;
               if (!last) pidx <= pidx + PKT_AW'(1);
            end
            default: ;
         endcase
      end
   end

   assign wr_en     = (state == WRITE);
   assign waddr     = wr_en ? pidx : waddr_q;
   assign wdata     = wr_en ? x : wdata_q;
   assign proc_done = (state == DONE);

endmodule

// File: tb/tb_polar_enc_engine.sv
// Scoreboard bench for polar_enc_engine: directed packets, expected writes
// and completion cycles queued by stimulus and checked by a monitor.
module tb_polar_enc_engine;

   localparam int LOG_NMAX = 9;
   localparam int NMAX     = 512;
   localparam int PKT_AW   = 6;
   localparam int RA_W     = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              module_en;
   logic [RA_W-1:0]   raddr;
   logic [NMAX-1:0]   rdata;
   logic              wr_en;
   logic [PKT_AW-1:0] waddr;
   logic [NMAX-1:0]   wdata;
   logic              proc_done;

   logic [NMAX-1:0]   mem [256];

   polar_enc_engine #(
      .LOG_NMAX(LOG_NMAX),
      .PKT_AW  (PKT_AW),
      .RA_W    (RA_W)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .module_en(module_en),
      .raddr    (raddr),
      .rdata    (rdata),
      .wr_en    (wr_en),
      .waddr    (waddr),
      .wdata    (wdata),
      .proc_done(proc_done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) rdata <= mem[raddr];

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      int              a;
      logic [NMAX-1:0] d;
      int              c;
   } wr_t;

   wr_t exp_q[$];
   int  done_q[$];
   int  t0 = 0;
   int  tests = 0;
   int  fails = 0;

   always @(negedge clk) begin
      wr_t e;
      int  dc;
      if (rst !== 1'b1) begin
         if (wr_en) begin
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_write addr=%0d cyc=%0d", waddr, cyc - t0);
            end else begin
               e = exp_q.pop_front();
               if (waddr !== PKT_AW'(e.a) || wdata !== e.d || cyc - t0 != e.c) begin
                  fails++;
                  $display("FAIL write got a=%0d c=%0d d=%h want a=%0d c=%0d d=%h",
                           waddr, cyc - t0, wdata, e.a, e.c, e.d);
               end
            end
         end
         if (proc_done) begin
            tests++;
            if (done_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_done cyc=%0d", cyc - t0);
            end else begin
               dc = done_q.pop_front();
               if (cyc - t0 != dc) begin
                  fails++;
                  $display("FAIL done_cycle got %0d want %0d", cyc - t0, dc);
               end
            end
         end
      end
   end

   function automatic logic [NMAX-1:0] b(int i);
      logic [NMAX-1:0] v;
      v    = '0;
      v[i] = 1'b1;
      return v;
   endfunction

   task automatic check(string nm, logic [NMAX-1:0] got, logic [NMAX-1:0] want);
      tests++;
      if (got !== want) begin
         fails++;
         $display("FAIL %s got %h want %h", nm, got, want);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = '0;
   endtask

   task automatic set_pkt(int p, int md, logic [NMAX-1:0] mk, logic [NMAX-1:0] u);
      mem[3*p+1] = NMAX'(md);
      mem[3*p+2] = mk;
      mem[3*p+3] = u;
   endtask

   task automatic push_wr(int a, logic [NMAX-1:0] d, int c);
      wr_t e;
      e.a = a;
      e.d = d;
      e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic start(int hold);
      @(negedge clk);
      t0        = cyc;
      module_en = 1'b1;
      repeat (hold) @(negedge clk);
      module_en = 1'b0;
   endtask

   task automatic wait_idle(int lim);
      int i;
      i = 0;
      while ((exp_q.size() != 0 || done_q.size() != 0) && i < lim) begin
         @(negedge clk);
         i++;
      end
      tests++;
      if (exp_q.size() != 0 || done_q.size() != 0) begin
         fails++;
         $display("FAIL timeout pending_writes=%0d pending_done=%0d",
                  exp_q.size(), done_q.size());
         exp_q.delete();
         done_q.delete();
      end
      repeat (5) @(negedge clk);
   endtask

   logic [NMAX-1:0] v;

   initial begin
      rst       = 1'b1;
      module_en = 1'b0;
      clear_mem();
      repeat (2) @(negedge clk);
      check("rst_raddr", NMAX'(raddr), '0);
      check("rst_wr_en", NMAX'(wr_en), '0);
      check("rst_waddr", NMAX'(waddr), '0);
      check("rst_wdata", wdata, '0);
      check("rst_done", NMAX'(proc_done), '0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      // single mode-0 packet, top info bit -> low 128 bits all ones
      clear_mem();
      mem[0] = NMAX'(1);
      set_pkt(0, 0, '0, b(127));
      v = '0;
      v[127:0] = '1;
      push_wr(0, v, 12);
      done_q.push_back(13);
      start(1);
      wait_idle(100);

      // mode 2 fully frozen -> zero codeword after 9 stages
      clear_mem();
      mem[0] = NMAX'(1);
      set_pkt(0, 2, '1, {16{$urandom()}});
      push_wr(0, '0, 14);
      done_q.push_back(15);
      start(1);
      wait_idle(100);

      // three packets of growing length
      clear_mem();
      mem[0] = NMAX'(3);
      set_pkt(0, 0, '0, b(0));
      set_pkt(1, 1, '0, b(0));
      set_pkt(2, 2, '0, b(0));
      push_wr(0, NMAX'(1), 12);
      push_wr(1, NMAX'(1), 24);
      push_wr(2, NMAX'(1), 37);
      done_q.push_back(38);
      start(1);
      wait_idle(200);

      // small hand-computed transforms, masking and out-of-range bits
      clear_mem();
      mem[0] = NMAX'(4);
      set_pkt(0, 0, '0, b(0) | b(1));
      set_pkt(1, 0, b(3), b(3));
      set_pkt(2, 0, '0, b(5) | b(200));
      set_pkt(3, 1, '0, b(255));
      v = '0;
      v[255:0] = '1;
      push_wr(0, NMAX'(2), 12);
      push_wr(1, '0, 23);
      push_wr(2, NMAX'('h33), 34);
      push_wr(3, v, 46);
      done_q.push_back(47);
      start(1);
      wait_idle(200);

      // zero packets, start held high across the short job
      clear_mem();
      mem[0] = '0;
      done_q.push_back(2);
      start(3);
      wait_idle(50);
      repeat (20) @(negedge clk);

      // reserved mode followed by a normal packet
      clear_mem();
      mem[0] = NMAX'(2);
      set_pkt(0, 3, '0, {16{$urandom()}});
      set_pkt(1, 0, '0, b(3));
      push_wr(0, '0, 5);
      push_wr(1, NMAX'('hF), 16);
      done_q.push_back(17);
      start(1);
      wait_idle(100);

      // packet count saturation, garbage above the count field
      clear_mem();
      mem[0] = NMAX'(127) | b(9);
      for (int p = 0; p < 64; p++) begin
         set_pkt(p, 3, '0, '1);
         push_wr(p, '0, 5 + 4 * p);
      end
      done_q.push_back(258);
      start(1);
      wait_idle(400);
      repeat (20) @(negedge clk);

      // reset during packet 1 encoding, then a clean rerun
      clear_mem();
      mem[0] = NMAX'(4);
      for (int p = 0; p < 4; p++) set_pkt(p, 0, '0, b(p));
      push_wr(0, NMAX'(1), 12);
      start(1);
      while (cyc < t0 + 18) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      check("abort_raddr", NMAX'(raddr), '0);
      check("abort_wr_en", NMAX'(wr_en), '0);
      check("abort_waddr", NMAX'(waddr), '0);
      check("abort_wdata", wdata, '0);
      check("abort_done", NMAX'(proc_done), '0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      wait_idle(10);
      repeat (60) @(negedge clk);
      push_wr(0, NMAX'(1), 12);
      push_wr(1, NMAX'(3), 23);
      push_wr(2, NMAX'(5), 34);
      push_wr(3, NMAX'('hF), 45);
      done_q.push_back(46);
      start(1);
      wait_idle(200);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
